// File: rtl/eth_gmii_rx_deframer.sv
// rtl/eth_gmii_rx_deframer.sv - GMII receive deframer: strips preamble/SFD and FCS, checks frame, counts good/bad
// A 5-byte pipe holds back the trailing FCS so it never reaches the stream.
module eth_gmii_rx_deframer #(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int CNT_W         = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [7:0]       gmii_rxd_i,
  input  logic             gmii_rx_dv_i,
  input  logic             gmii_rx_er_i,
  output logic [7:0]       m_axis_tdata_o,
  output logic             m_axis_tvalid_o,
  output logic             m_axis_tlast_o,
  output logic             m_axis_tuser_o,
  output logic [CNT_W-1:0] good_cnt_o,
  output logic [CNT_W-1:0] bad_cnt_o
);

  localparam int          LEN_W       = $clog2(MAX_FRAME_LEN + 2);
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {S_DISCARD, S_IDLE, S_PREAMBLE, S_PAYLOAD} state_t;

  state_t           state_q, state_d;
  logic [7:0]       pipe_q [5];
  logic [7:0]       pipe_d [5];
  logic [2:0]       fill_q, fill_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      crc_q, crc_d;
  logic             err_q, err_d;
  logic [7:0]       tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;
  logic             tuser_q, tuser_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] bad_q, bad_d;
  logic             frame_bad;

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    pipe_d    = pipe_q;
    fill_d    = fill_q;
    len_d     = len_q;
    crc_d     = crc_q;
    err_d     = err_q;
    tdata_d   = tdata_q;
    tvalid_d  = 1'b0;
    tlast_d   = 1'b0;
    tuser_d   = 1'b0;
    good_d    = good_q;
    bad_d     = bad_q;
    frame_bad = (crc_q != CRC_RESIDUE) || err_q || (len_q < LEN_W'(MIN_FRAME_LEN));

    unique case (state_q)
      S_DISCARD: begin
        if (!gmii_rx_dv_i) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (gmii_rx_dv_i) state_d = (gmii_rxd_i == 8'h55) ? S_PREAMBLE : S_DISCARD;
      end
      S_PREAMBLE: begin
        if (!gmii_rx_dv_i) begin
          state_d = S_IDLE;
        end else if (gmii_rxd_i == 8'hD5) begin
          state_d = S_PAYLOAD;
          fill_d  = 3'd0;
          len_d   = '0;
          crc_d   = 32'hFFFF_FFFF;
          err_d   = 1'b0;
        end else if (gmii_rxd_i != 8'h55) begin
          state_d = S_DISCARD;
        end
      end
      S_PAYLOAD: begin
        if (gmii_rx_dv_i) begin
          pipe_d[0] = gmii_rxd_i;
          for (int i = 4; i > 0; i--) pipe_d[i] = pipe_q[i-1];
          if (fill_q != 3'd5) fill_d = fill_q + 3'd1;
          crc_d = crc_next(crc_q, gmii_rxd_i);
          if (len_q != LEN_W'(MAX_FRAME_LEN + 1)) len_d = len_q + 1'b1;
          err_d = err_q | gmii_rx_er_i;
          if (fill_q == 3'd5) begin
            tvalid_d = 1'b1;
            tdata_d  = pipe_q[4];
          end
          // Oversize: truncate on the byte at index MAX_FRAME_LEN, drop the rest.
          if (len_q == LEN_W'(MAX_FRAME_LEN)) begin
            tlast_d = 1'b1;
            tuser_d = 1'b1;
            bad_d   = bad_q + 1'b1;
            state_d = S_DISCARD;
          end
        end else begin
          if (fill_q == 3'd5) begin
            tvalid_d = 1'b1;
            tdata_d  = pipe_q[4];
            tlast_d  = 1'b1;
            tuser_d  = frame_bad;
          end
          if (frame_bad) bad_d = bad_q + 1'b1;
          else           good_d = good_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_DISCARD;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_DISCARD;
      for (int i = 0; i < 5; i++) pipe_q[i] <= 8'h00;
      fill_q   <= 3'd0;
      len_q    <= '0;
      crc_q    <= 32'hFFFF_FFFF;
      err_q    <= 1'b0;
      tdata_q  <= 8'h00;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      good_q   <= '0;
      bad_q    <= '0;
    end else begin
      state_q  <= state_d;
      pipe_q   <= pipe_d;
      fill_q   <= fill_d;
      len_q    <= len_d;
      crc_q    <= crc_d;
      err_q    <= err_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
    end
  end

  assign m_axis_tdata_o  = tdata_q;
  assign m_axis_tvalid_o = tvalid_q;
  assign m_axis_tlast_o  = tlast_q;
  assign m_axis_tuser_o  = tuser_q;
  assign good_cnt_o      = good_q;
  assign bad_cnt_o       = bad_q;

endmodule

// File: tb/tb_eth_gmii_rx_deframer.sv
// tb/tb_eth_gmii_rx_deframer.sv - directed self-checking bench for eth_gmii_rx_deframer
module tb_eth_gmii_rx_deframer;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {logic [7:0] d; logic l; logic u;} beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rxd = 8'h00;
  logic        rx_dv = 1'b0;
  logic        rx_er = 1'b0;
  logic [7:0]  tdata, tdata2;
  logic        tvalid, tlast, tuser, tvalid2, tlast2, tuser2;
  logic [15:0] good_cnt, bad_cnt;
  logic [1:0]  good2, bad2;

  int errors = 0;
  int checks = 0;
  beat_t beats[$];
  beat_t exp_q[$];

  eth_gmii_rx_deframer dut (
    .clk_i(clk), .rst_i(rst), .gmii_rxd_i(rxd), .gmii_rx_dv_i(rx_dv), .gmii_rx_er_i(rx_er),
    .m_axis_tdata_o(tdata), .m_axis_tvalid_o(tvalid), .m_axis_tlast_o(tlast),
    .m_axis_tuser_o(tuser), .good_cnt_o(good_cnt), .bad_cnt_o(bad_cnt)
  );

  eth_gmii_rx_deframer #(.CNT_W(2)) dut_w (
    .clk_i(clk), .rst_i(rst), .gmii_rxd_i(rxd), .gmii_rx_dv_i(rx_dv), .gmii_rx_er_i(rx_er),
    .m_axis_tdata_o(tdata2), .m_axis_tvalid_o(tvalid2), .m_axis_tlast_o(tlast2),
    .m_axis_tuser_o(tuser2), .good_cnt_o(good2), .bad_cnt_o(bad2)
  );

  always #4 clk = ~clk;

  always @(negedge clk) begin
    if (tvalid) beats.push_back({tdata, tlast, tuser});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bq_t ramp(input int n, input int base);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'(base + i));
    return q;
  endfunction

  function automatic bq_t with_fcs(input bq_t p);
    bq_t q;
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    q = p;
    foreach (p[i]) begin
      c = c ^ {24'h0, p[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) q.push_back(c[8*i +: 8]);
    return q;
  endfunction

  task automatic push_exp(input bq_t p, input int n, input logic user);
    for (int i = 0; i < n; i++) exp_q.push_back({p[i], i == n - 1, (i == n - 1) & user});
  endtask

  task automatic check_beats(input string tag);
    int mism;
    mism = 0;
    check({tag, "_nbeats"}, beats.size(), exp_q.size());
    for (int i = 0; i < beats.size() && i < exp_q.size(); i++) begin
      if (beats[i] !== exp_q[i]) mism++;
    end
    check({tag, "_beat_mismatches"}, mism, 0);
    beats.delete();
    exp_q.delete();
  endtask

  task automatic put(input logic dv, input logic [7:0] d, input logic er);
    rx_dv = dv;
    rxd   = d;
    rx_er = er;
    @(negedge clk);
  endtask

  task automatic send(input bq_t f, input int er_at, input int gap);
    repeat (7) put(1'b1, 8'h55, 1'b0);
    put(1'b1, 8'hD5, 1'b0);
    foreach (f[i]) put(1'b1, f[i], i == er_at);
    repeat (gap) put(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    bq_t p, f;

    @(negedge clk);
    @(negedge clk);
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tuser", tuser, 0);
    check("rst_tdata", tdata, 0);
    check("rst_good", good_cnt, 0);
    check("rst_bad", bad_cnt, 0);
    rst = 1'b0;
    repeat (2) put(1'b0, 8'h00, 1'b0);

    p = ramp(60, 0);
    send(with_fcs(p), -1, 3);
    push_exp(p, 60, 1'b0);
    check_beats("good");
    check("good_gcnt", good_cnt, 1);
    check("good_bcnt", bad_cnt, 0);

    f = with_fcs(p);
    f[60] = f[60] ^ 8'h01;
    send(f, -1, 3);
    push_exp(p, 60, 1'b1);
    check_beats("fcs_flip");
    check("fcs_flip_bcnt", bad_cnt, 1);

    send(with_fcs(p), 20, 3);
    push_exp(p, 60, 1'b1);
    check_beats("rx_er");
    check("rx_er_bcnt", bad_cnt, 2);
    check("rx_er_gcnt", good_cnt, 1);

    p = ramp(59, 8'h10);
    send(with_fcs(p), -1, 3);
    push_exp(p, 59, 1'b1);
    check_beats("len63");
    check("len63_bcnt", bad_cnt, 3);

    send(ramp(3, 1), -1, 3);
    check_beats("len3");
    check("len3_bcnt", bad_cnt, 4);

    send(ramp(5, 8'hA0), -1, 3);
    push_exp(ramp(1, 8'hA0), 1, 1'b1);
    check_beats("len5");
    check("len5_bcnt", bad_cnt, 5);

    send(ramp(1530, 0), -1, 4);
    push_exp(ramp(1514, 0), 1514, 1'b1);
    check_beats("oversize");
    check("oversize_bcnt", bad_cnt, 6);
    check("oversize_gcnt", good_cnt, 1);

    p = ramp(60, 8'h40);
    f = ramp(60, 8'h80);
    send(with_fcs(p), -1, 1);
    send(with_fcs(f), -1, 3);
    push_exp(p, 60, 1'b0);
    push_exp(f, 60, 1'b0);
    check_beats("b2b");
    check("b2b_gcnt", good_cnt, 3);
    check("b2b_bcnt", bad_cnt, 6);

    send(with_fcs(p), -1, 1);
    put(1'b1, 8'h55, 1'b0);
    put(1'b1, 8'h12, 1'b0);
    put(1'b1, 8'h34, 1'b0);
    put(1'b0, 8'h00, 1'b0);
    send(with_fcs(f), -1, 3);
    push_exp(p, 60, 1'b0);
    push_exp(f, 60, 1'b0);
    check_beats("badpre");
    check("badpre_gcnt", good_cnt, 5);
    check("badpre_bcnt", bad_cnt, 6);
    check("wrap_pre_gcnt", good2, 1);
    check("wrap_pre_bcnt", bad2, 2);

    p = ramp(60, 0);
    f = with_fcs(p);
    repeat (7) put(1'b1, 8'h55, 1'b0);
    put(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 30; i++) put(1'b1, f[i], 1'b0);
    rst = 1'b1;
    put(1'b1, f[30], 1'b0);
    beats.delete();
    check("midrst_tvalid", tvalid, 0);
    check("midrst_gcnt", good_cnt, 0);
    check("midrst_bcnt", bad_cnt, 0);
    put(1'b1, f[31], 1'b0);
    rst = 1'b0;
    for (int i = 32; i < 64; i++) put(1'b1, f[i], 1'b0);
    repeat (3) put(1'b0, 8'h00, 1'b0);
    check_beats("midrst_drop");
    check("midrst_after_gcnt", good_cnt, 0);
    check("midrst_after_bcnt", bad_cnt, 0);

    send(f, -1, 3);
    push_exp(p, 60, 1'b0);
    check_beats("post_rst");
    check("post_rst_gcnt", good_cnt, 1);
    check("post_rst_bcnt", bad_cnt, 0);

    repeat (4) send(f, -1, 2);
    repeat (2) put(1'b0, 8'h00, 1'b0);
    beats.delete();
    check("wrap_main_gcnt", good_cnt, 5);
    check("wrap_gcnt", good2, 1);
    check("wrap_bcnt", bad2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
